// File: rtl/lighthouse_pkg.sv
// lighthouse_pkg
// Shared definitions for the lighthouse pulse generator and the benches
// around it: the frame FSM state encoding, the reset-time frame timing
// and the config record carried through the valid/ready config port.
package lighthouse_pkg;

    // Width of the offset/period fields and of the frame counter
    localparam int CFG_CNT_W = 16;

    // Reset-time frame timing, in clock cycles
    localparam int DEF_WIDTH  = 2;
    localparam int DEF_GAP    = 2;
    localparam int DEF_OFFSET = 50;
    localparam int DEF_PERIOD = 100;

    // Segments of one frame, in the order they occur
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_A,
        ST_GAP,
        ST_SYNC_B,
        ST_WAIT,
        ST_SWEEP,
        ST_TAIL
    } lh_state_t;

    // One complete frame timing set
    typedef struct packed {
        logic [7:0]           width;
        logic [7:0]           gap;
        logic [CFG_CNT_W-1:0] offset;
        logic [CFG_CNT_W-1:0] period;
    } lh_cfg_t;

endpackage

// File: rtl/lh_cfg_check.sv
// lh_cfg_check
// Combinational validity check of a frame config.
// Ports:
//   cfg  in   config record {width, gap, offset, period}
//   ok   out  high when the config describes a well-formed frame
module lh_cfg_check
    import lighthouse_pkg::*;
(
    input  lh_cfg_t cfg,
    output logic    ok
);

    // One extra bit so offset+width cannot wrap and pass the period check
    localparam int XW = CFG_CNT_W + 1;

    logic [XW-1:0] w;
    logic [XW-1:0] g;
    logic [XW-1:0] o;
    logic [XW-1:0] p;
    logic [XW-1:0] sync_end;
    logic [XW-1:0] sweep_end;

    // The sweep must start at least one low cycle after sync B ends, and
    // must finish no later than the end of the frame.
    always_comb begin
        w         = XW'(cfg.width);
        g         = XW'(cfg.gap);
        o         = XW'(cfg.offset);
        p         = XW'(cfg.period);
        sync_end  = (w << 1) + g + XW'(1);
        sweep_end = o + w;
        ok        = (w != '0) && (g != '0) && (o >= sync_end) && (sweep_end <= p);
    end

endmodule

// File: rtl/lighthouse_pulse_gen.sv
// lighthouse_pulse_gen
// Emits framed lighthouse pulse trains: sync A, gap, sync B, then one sweep
// pulse at a programmable offset, repeated while en is held high.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   en                  run request (sampled at frame end and while idle)
//   cfg_valid/ready     config handshake; cfg_ready low while a config is pending
//   cfg_width/gap       pulse width and sync gap in cycles
//   cfg_offset/period   sweep start and frame length in cycles
//   cfg_err             one-cycle strobe after a rejected config
//   pulse               registered protocol output
//   frame_start/done    strobes on the first and last cycle of each frame
//   busy                high whenever a frame is in progress
module lighthouse_pulse_gen #(
    parameter int CNT_W      = lighthouse_pkg::CFG_CNT_W,
    parameter int DEF_WIDTH  = lighthouse_pkg::DEF_WIDTH,
    parameter int DEF_GAP    = lighthouse_pkg::DEF_GAP,
    parameter int DEF_OFFSET = lighthouse_pkg::DEF_OFFSET,
    parameter int DEF_PERIOD = lighthouse_pkg::DEF_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [7:0]       cfg_width,
    input  logic [7:0]       cfg_gap,
    input  logic [CNT_W-1:0] cfg_offset,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             cfg_err,
    output logic             pulse,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    import lighthouse_pkg::*;

    localparam int XW = CNT_W + 1;
    localparam int PW = CFG_CNT_W;

    lh_state_t      state;
    lh_state_t      state_nxt;
    logic [CNT_W-1:0] t;
    lh_cfg_t        act;
    lh_cfg_t        pend;
    lh_cfg_t        offer;
    logic           pend_valid;
    logic           offer_ok;
    logic           accept;
    logic           load;
    logic           end_frame;
    logic           start_frame;

    logic [XW-1:0]  t1;
    logic [XW-1:0]  w;
    logic [XW-1:0]  g;
    logic [XW-1:0]  o;
    logic [XW-1:0]  p;

    assign offer = '{width:  cfg_width,
                     gap:    cfg_gap,
                     offset: PW'(cfg_offset),
                     period: PW'(cfg_period)};

    lh_cfg_check u_check (
        .cfg (offer),
        .ok  (offer_ok)
    );

    assign cfg_ready = ~pend_valid;
    assign accept    = cfg_valid & cfg_ready;
    // A pending config only ever lands at a frame boundary or while idle.
    // Because accept needs an empty pending slot, a config accepted on the
    // boundary edge itself cannot be picked up by that boundary.
    assign load      = pend_valid & (start_frame | (state == ST_IDLE));

    // Segment boundaries are found by comparing the count of the upcoming
    // cycle (t+1) against the active timing, so each state change lands
    // exactly on the first cycle of the next segment.
    always_comb begin
        t1          = XW'(t) + XW'(1);
        w           = XW'(act.width);
        g           = XW'(act.gap);
        o           = XW'(act.offset);
        p           = XW'(act.period);
        end_frame   = (state != ST_IDLE) && (t1 == p);
        start_frame = en && ((state == ST_IDLE) || end_frame);
        state_nxt   = state;
        if (start_frame) begin
            state_nxt = ST_SYNC_A;
        end else if (end_frame) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_SYNC_A: if (t1 == w)            state_nxt = ST_GAP;
                ST_GAP:    if (t1 == w + g)        state_nxt = ST_SYNC_B;
                ST_SYNC_B: if (t1 == (w << 1) + g) state_nxt = ST_WAIT;
                ST_WAIT:   if (t1 == o)            state_nxt = ST_SWEEP;
                ST_SWEEP:  if (t1 == o + w)        state_nxt = ST_TAIL;
                default:                           state_nxt = state;
            endcase
        end
    end

    // Frame FSM, frame counter, config registers and registered outputs.
    // Outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            t           <= '0;
            pulse       <= 1'b0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            cfg_err     <= 1'b0;
            pend_valid  <= 1'b0;
            pend        <= '0;
            act         <= '{width:  8'(DEF_WIDTH),
                             gap:    8'(DEF_GAP),
                             offset: PW'(DEF_OFFSET),
                             period: PW'(DEF_PERIOD)};
        end else begin
            state       <= state_nxt;
            t           <= (start_frame || state_nxt == ST_IDLE) ? '0 : t + CNT_W'(1);
            pulse       <= state_nxt inside {ST_SYNC_A, ST_SYNC_B, ST_SWEEP};
            busy        <= state_nxt != ST_IDLE;
            frame_start <= start_frame;
            // A valid frame is at least five cycles, so the last cycle can
            // never be the first one; mid-frame the active period is stable.
            frame_done  <= !start_frame && (state_nxt != ST_IDLE) && (t1 + XW'(1) == p);
            cfg_err     <= accept && !offer_ok;

            if (load) begin
                act <= pend;
            end

            if (accept && offer_ok) begin
                pend       <= offer;
                pend_valid <= 1'b1;
            end else if (load) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lighthouse_pulse_gen.sv
// tb_lighthouse_pulse_gen
// Directed bench for lighthouse_pulse_gen: a table of configs applied to
// the validity checker, then hand-built frame sequences walked cycle by
// cycle against the frame timeline.
module tb_lighthouse_pulse_gen;

    import lighthouse_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_gap;
    logic [15:0] cfg_offset;
    logic [15:0] cfg_period;
    logic        cfg_err;
    logic        pulse;
    logic        frame_start;
    logic        frame_done;
    logic        busy;

    lh_cfg_t     chk_cfg;
    logic        chk_ok;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        int width;
        int gap;
        int offset;
        int period;
        bit ok;
    } cfg_vec_t;

    cfg_vec_t vecs[10];

    lighthouse_pulse_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_width   (cfg_width),
        .cfg_gap     (cfg_gap),
        .cfg_offset  (cfg_offset),
        .cfg_period  (cfg_period),
        .cfg_err     (cfg_err),
        .pulse       (pulse),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    lh_cfg_check u_ref (
        .cfg (chk_cfg),
        .ok  (chk_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setCfg(input int w, input int g, input int o, input int p);
        cfg_width  = 8'(w);
        cfg_gap    = 8'(g);
        cfg_offset = 16'(o);
        cfg_period = 16'(p);
    endtask

    // Walk one frame from its t=0 cycle (called at the falling edge of t=0),
    // optionally offering the current cfg_* at offer_at and dropping en at
    // drop_at. Returns at the falling edge of cycle stop_at.
    task automatic applyStimulus(input int w, input int g, input int o, input int p,
                                 input int offer_at, input bit offer_ok,
                                 input bit hold_pending, input int drop_at,
                                 input int stop_at);
        bit exp_pulse;
        bit exp_ready;
        bit exp_err;
        for (int t = 0; t < stop_at; t++) begin
            cfg_valid = (t == offer_at);
            if (t == drop_at) en = 1'b0;
            exp_pulse = (t < w) || (t >= w + g && t < 2 * w + g) || (t >= o && t < o + w);
            exp_ready = !(hold_pending || (offer_ok && offer_at >= 0 && t > offer_at));
            exp_err   = (offer_at >= 0) && !offer_ok && (t == offer_at + 1);
            checkOutput($sformatf("pulse t=%0d", t), 32'(pulse), 32'(exp_pulse));
            checkOutput($sformatf("frame_start t=%0d", t), 32'(frame_start), 32'(t == 0));
            checkOutput($sformatf("frame_done t=%0d", t), 32'(frame_done), 32'(t == p - 1));
            checkOutput($sformatf("busy t=%0d", t), 32'(busy), 32'd1);
            checkOutput($sformatf("cfg_ready t=%0d", t), 32'(cfg_ready), 32'(exp_ready));
            checkOutput($sformatf("cfg_err t=%0d", t), 32'(cfg_err), 32'(exp_err));
            @(negedge clk);
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2,   2,   50,    100,   1'b1};
        vecs[1] = '{0,   2,   50,    100,   1'b0};
        vecs[2] = '{2,   0,   50,    100,   1'b0};
        vecs[3] = '{15,  15,  20,    1000,  1'b0};
        vecs[4] = '{15,  15,  46,    1000,  1'b1};
        vecs[5] = '{15,  15,  45,    1000,  1'b0};
        vecs[6] = '{15,  15,  500,   515,   1'b1};
        vecs[7] = '{15,  15,  500,   514,   1'b0};
        vecs[8] = '{255, 255, 65535, 65535, 1'b0};
        vecs[9] = '{1,   1,   4,     5,     1'b1};

        rst       = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        setCfg(0, 0, 0, 0);
        chk_cfg   = '0;

        // Validity checker against hand-derived verdicts
        for (int i = 0; i < 10; i++) begin
            chk_cfg.width  = 8'(vecs[i].width);
            chk_cfg.gap    = 8'(vecs[i].gap);
            chk_cfg.offset = 16'(vecs[i].offset);
            chk_cfg.period = 16'(vecs[i].period);
            #1;
            checkOutput($sformatf("cfg_check vec %0d", i), 32'(chk_ok), 32'(vecs[i].ok));
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset pulse", 32'(pulse), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frame_start", 32'(frame_start), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle busy", 32'(busy), 32'd0);

        // Two default frames back to back, then a mid-frame reconfig
        en = 1'b1;
        @(negedge clk);
        applyStimulus(2, 2, 50, 100, -1, 1'b0, 1'b0, -1, 100);
        applyStimulus(2, 2, 50, 100, -1, 1'b0, 1'b0, -1, 100);
        setCfg(15, 15, 500, 1000);
        applyStimulus(2, 2, 50, 100, 10, 1'b1, 1'b0, -1, 100);
        applyStimulus(15, 15, 500, 1000, -1, 1'b0, 1'b0, -1, 1000);

        // Invalid config is rejected and leaves the waveform alone
        setCfg(15, 15, 20, 1000);
        applyStimulus(15, 15, 500, 1000, 10, 1'b0, 1'b0, -1, 1000);

        // Config accepted on the last cycle waits one extra frame
        setCfg(2, 2, 50, 100);
        applyStimulus(15, 15, 500, 1000, 999, 1'b1, 1'b0, -1, 1000);
        applyStimulus(15, 15, 500, 1000, -1, 1'b0, 1'b1, -1, 1000);

        // en dropped mid-frame: frame completes, then stays idle
        applyStimulus(2, 2, 50, 100, -1, 1'b0, 1'b0, 30, 100);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("post-stop busy %0d", i), 32'(busy), 32'd0);
            checkOutput($sformatf("post-stop pulse %0d", i), 32'(pulse), 32'd0);
            checkOutput($sformatf("post-stop frame_start %0d", i), 32'(frame_start), 32'd0);
            @(negedge clk);
        end

        // Reset inside the sweep, with a pending config that must be lost
        setCfg(3, 3, 60, 120);
        en = 1'b1;
        @(negedge clk);
        applyStimulus(2, 2, 50, 100, 10, 1'b1, 1'b0, -1, 51);
        checkOutput("sweep before reset", 32'(pulse), 32'd1);
        rst = 1'b0;
        en  = 1'b0;
        #1;
        checkOutput("async reset pulse", 32'(pulse), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("after reset busy", 32'(busy), 32'd0);
        en = 1'b1;
        @(negedge clk);
        applyStimulus(2, 2, 50, 100, -1, 1'b0, 1'b0, 0, 100);
        checkOutput("final busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/lighthouse_pulse_gen.md
# lighthouse_pulse_gen

Transmit-side generator for the lighthouse optical pulse protocol: emits framed pulse trains (sync pulse pair followed by one sweep pulse at a programmable offset) on a single-bit `pulse` line. It is the stimulus source for `PulseIntervalDetector` on board loopback and in system benches. Frame timing is held in active registers that are updated only at frame boundaries through a valid/ready config port.

## Interface
- CNT_W, 16, width of the offset, period and frame counters
- DEF_WIDTH, 2, reset value of pulse width in cycles
- DEF_GAP, 2, reset value of the low gap between the two sync pulses
- DEF_OFFSET, 50, reset value of the sweep-pulse start, measured from frame start
- DEF_PERIOD, 100, reset value of the frame length in cycles

Ports:
- clk  in  1  sole clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  run request; level-sensitive
- cfg_valid  in  1  config offer
- cfg_ready  out  1  high when no config is pending
- cfg_width  in  8  pulse width
- cfg_gap  in  8  sync gap
- cfg_offset  in  CNT_W  sweep start
- cfg_period  in  CNT_W  frame length
- cfg_err  out  1  one-cycle strobe: the offered config was rejected
- pulse  out  1  registered protocol output
- frame_start  out  1  one-cycle strobe, coincident with the first high cycle of sync A
- frame_done  out  1  one-cycle strobe on the last cycle of a frame (t = P-1)
- busy  out  1  high whenever the state is not IDLE

## Operation
- Frame timeline, with t the frame counter, 0 at frame start, and W/G/O/P the active config:
  - `pulse` is high for t in [0,W) (sync A), then low for [W,W+G).
  - `pulse` is high for [W+G, 2W+G) (sync B), then low until O.
  - `pulse` is high for [O, O+W) (sweep), then low until P-1.
- FSM states and transitions:
  - IDLE -> SYNC_A -> GAP -> SYNC_B -> WAIT -> SWEEP -> TAIL.
  - TAIL -> SYNC_A when en=1 at t=P-1; otherwise TAIL -> IDLE.
- en=0 mid-frame: the current frame completes, then the FSM goes to IDLE. There is never a truncated frame.
- Config handshake:
  - A config is accepted on cfg_valid & cfg_ready.
  - The accepted config is latched into a pending register and cfg_ready drops.
  - The pending config is copied to the active config at the next frame start, or on the next cycle if the FSM is IDLE. cfg_ready then rises.
- Validity checks are made at acceptance, in CNT_W+1-bit arithmetic:
  - W ≥ 1 and G ≥ 1
  - O ≥ 2W+G+1
  - O+W ≤ P
- A config that fails any check is handshaken but discarded. cfg_err pulses for exactly one cycle, the next cycle, and the active config is unchanged.
- Reset values: pulse=0, busy=0, frame_start=0, frame_done=0, cfg_err=0, cfg_ready=1, FSM=IDLE, active config = DEF_*, no pending config.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). Any pending config is lost.

## Timing
- If en is sampled high at edge k while IDLE, `pulse` and `frame_start` are high in the cycle after edge k.
- Back-to-back frames: the cycle after frame_done is the first sync A cycle, with no idle cycle between frames.
- A pending config accepted in cycle t ≤ P-2 applies to the next frame.
- If acceptance coincides with t=P-1, the config applies to the frame after next. A frame boundary never uses a config accepted in the same cycle.
- The counter is sized to CNT_W bits and never wraps within a valid frame.

## Structure
- Shared package `lighthouse_pkg` holds:
  - the FSM state enum
  - the DEF_* constants
  - a config struct {width, gap, offset, period}, also usable by `PulseIntervalDetector` benches.
- One sub-module, `lh_cfg_check`: combinational validity check on a config struct, outputs `ok`. It is reused by the bench scoreboard.

## Test plan
- Defaults: release reset, hold en=1 for 2 frames.
  - pulse is high at t = 0–1, 4–5 and 50–51 of each frame.
  - frame_done is at t=99; the next frame_start follows one cycle later.
- Reconfigure mid-frame: W=15, G=15, O=500, P=1000, accepted at t=10.
  - The current frame keeps the defaults.
  - The next frame has pulses at 0–14, 30–44 and 500–514.
  - cfg_ready stays low until that frame starts.
- Invalid config: O=20 with W=15, G=15 (fails O ≥ 2W+G+1).
  - cfg_err is high for one cycle.
  - Waveform unchanged.
  - cfg_ready stays 1.
- Drop en at t=30 of a default frame: the frame completes, busy falls the cycle after frame_done, and pulse stays 0 afterwards.
- Assert rst=0 at t=51 (inside sweep): pulse=0 and busy=0 immediately; restarting after release begins with a clean sync A.
- Loopback into `PulseIntervalDetector`: sequence of offsets 500/100/700/100 with P=1000. The detector reports the sync-to-sweep intervals matching each offset.
